// File: rtl/twos_comp_pkg.sv
// Shared definitions for the bit-serial two's-complement negation stage:
// default operand width, counter width and the controller state encoding.
package twos_comp_pkg;

  localparam int TWOS_COMP_WIDTH = 12;
  localparam int TWOS_COMP_CNT_W = $clog2(TWOS_COMP_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/twos_comp_bit_cell.sv
// Serial negation cell: copies bits through until the first one has been
// seen, then inverts every following bit. Holds the first-one flag.
module twos_comp_bit_cell (
  input  logic t_clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic din,
  input  logic neg,
  output logic res
);

  logic flag;

  // First-one flag: cleared at word load, set once a one has passed through.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values and simulation matches the synthesized hardware.
  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      flag <= 1'b0;
    end else if (clear) begin
      flag <= 1'b0;
    end else if (en && neg) begin
      flag <= flag | din;
    end
  end

  assign res = neg ? (din ^ flag) : din;

endmodule

// File: rtl/serial_twos_comp.sv
// Bit-serial two's-complement negation stage (LSB first, one bit per clock).
// Optional build macro: TWOS_COMP_OVF_EN compiles in the most-negative-value
// overflow detector; without it out_ovf is tied low.
module serial_twos_comp
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = TWOS_COMP_WIDTH
) (
  input  logic             t_clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_neg,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   resreg;
  logic [WIDTH-1:0]   res_next;
  logic [CNT_W-1:0]   cnt;
  logic               neg_q;
  logic               res_bit;
  logic               accept;
  logic               finish;
  logic               release_w;

  assign accept    = (state == IDLE) && in_valid;
  assign finish    = (state == SHIFT) && (cnt == LAST);
  assign release_w = (state == DONE) && out_ready;
  assign res_next  = {res_bit, resreg[WIDTH-1:1]};

  twos_comp_bit_cell u_cell (
    .t_clk (t_clk),
    .rst   (rst),
    .clear (accept),
    .en    (state == SHIFT),
    .din   (shreg[0]),
    .neg   (neg_q),
    .res   (res_bit)
  );

  // Controller: load on accept, shift one bit per cycle, hold result in DONE.
  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      resreg   <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= in_data;
            neg_q <= in_neg;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg  <= shreg >> 1;
          resreg <= res_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            out_zero <= (res_next == '0);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_zero <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TWOS_COMP_OVF_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_pend;

  // Overflow: only the most negative operand negates to itself.
  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      ovf_pend <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        ovf_pend <= in_neg && (in_data == MOST_NEG);
      end
      if (finish) begin
        out_ovf <= ovf_pend;
      end else if (release_w) begin
        out_ovf <= 1'b0;
      end
    end
  end
`else
  assign out_ovf = 1'b0;
`endif

  assign in_ready  = (state == IDLE);
  assign ser_valid = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign out_data  = resreg;
  // The cell output is only meaningful while shifting; keep the pin quiet otherwise.
  assign ser_bit   = ser_valid & res_bit;

endmodule

// File: tb/tb_serial_twos_comp.sv
// Self-checking bench for serial_twos_comp: table of directed words plus
// hand-written reset-mid-shift and back-to-back sequences.
module tb_serial_twos_comp;

`ifdef TWOS_COMP_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        t_clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic        in_neg = 1'b0;
  logic        ser_bit;
  logic        ser_valid;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_data;
  logic        out_zero;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  int last_acc = 0;
  int last_rel = 0;

  serial_twos_comp #(.WIDTH(12)) dut (
    .t_clk     (t_clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_neg    (in_neg),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  always #5 t_clk = ~t_clk;

  always @(posedge t_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic        neg;
    logic [11:0] data;
    logic [11:0] exp;
    logic        zero;
    logic        ovf;
    int          hold;
    logic        early;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Push one word through: accept, collect the serial stream, check the
  // parallel result, optionally stall in DONE, then release.
  task automatic run_word(input logic neg, input logic [11:0] data, input logic [11:0] exp,
                          input logic ez, input logic eo, input int hold,
                          input logic early, input string tag);
    logic [11:0] ser_w;
    int          nser;
    int          lat;
    bit          got;
    ser_w = '0;
    nser  = 0;
    lat   = 0;
    got   = 0;
    @(negedge t_clk);
    check({tag, " in_ready idle"}, in_ready, 1);
    in_valid  = 1'b1;
    in_data   = data;
    in_neg    = neg;
    out_ready = early;
    last_acc  = edge_cnt + 1;
    @(posedge t_clk);
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge t_clk);
      if (out_valid) begin
        got = 1;
        lat = cyc - 1;
      end else if (ser_valid) begin
        if (nser < 12) ser_w[nser] = ser_bit;
        nser++;
      end
      if (cyc == 1) begin
        in_valid = 1'b0;
        in_data  = ~data;
        in_neg   = ~neg;
      end
    end
    check({tag, " latency"}, lat, 12);
    check({tag, " ser count"}, nser, 12);
    check({tag, " ser stream"}, ser_w, exp);
    check({tag, " out_data"}, out_data, exp);
    check({tag, " out_zero"}, out_zero, ez);
    check({tag, " out_ovf"}, out_ovf, eo);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 12'h123;
      in_neg   = 1'b1;
      @(negedge t_clk);
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold data"}, out_data, exp);
      check({tag, " hold in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    last_rel  = edge_cnt + 1;
    @(posedge t_clk);
    #1;
    check({tag, " released valid"}, out_valid, 0);
    check({tag, " released in_ready"}, in_ready, 1);
  endtask

  initial begin
    int prev_acc;
    int prev_rel;

    vecs[0] = '{1'b1, 12'h001, 12'hFFF, 1'b0, 1'b0,   0, 1'b1};
    vecs[1] = '{1'b1, 12'h0A4, 12'hF5C, 1'b0, 1'b0,   0, 1'b0};
    vecs[2] = '{1'b1, 12'h800, 12'h800, 1'b0, OVF_ON, 0, 1'b0};
    vecs[3] = '{1'b1, 12'h000, 12'h000, 1'b1, 1'b0,   0, 1'b0};
    vecs[4] = '{1'b0, 12'h5A3, 12'h5A3, 1'b0, 1'b0,   5, 1'b0};
    vecs[5] = '{1'b1, 12'h555, 12'hAAB, 1'b0, 1'b0,   0, 1'b0};
    vecs[6] = '{1'b1, 12'hFFF, 12'h001, 1'b0, 1'b0,   0, 1'b0};
    vecs[7] = '{1'b0, 12'h800, 12'h800, 1'b0, 1'b0,   0, 1'b0};

    repeat (2) @(posedge t_clk);
    @(negedge t_clk);
    check("reset in_ready", in_ready, 1);
    check("reset ser_valid", ser_valid, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i].neg, vecs[i].data, vecs[i].exp, vecs[i].zero, vecs[i].ovf,
               vecs[i].hold, vecs[i].early, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a word, then confirm the next word is clean.
    @(negedge t_clk);
    in_valid = 1'b1;
    in_data  = 12'h0A4;
    in_neg   = 1'b1;
    @(posedge t_clk);
    @(negedge t_clk);
    in_valid = 1'b0;
    repeat (5) @(negedge t_clk);
    check("mid ser_valid", ser_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst ser_valid", ser_valid, 0);
    check("rst ser_bit", ser_bit, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_zero", out_zero, 0);
    check("rst out_ovf", out_ovf, 0);
    @(negedge t_clk);
    rst = 1'b0;
    run_word(1'b1, 12'h001, 12'hFFF, 1'b0, 1'b0, 0, 1'b0, "post_rst");

    // Back-to-back: second word accepted on the edge after the release.
    run_word(1'b1, 12'h7FF, 12'h801, 1'b0, 1'b0, 0, 1'b1, "b2b_a");
    prev_acc = last_acc;
    prev_rel = last_rel;
    run_word(1'b1, 12'h001, 12'hFFF, 1'b0, 1'b0, 0, 1'b1, "b2b_b");
    check("b2b accept edge", last_acc, prev_rel + 1);
    check("b2b throughput", last_acc - prev_acc, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
